caesar_digit_stepper: RTL and testbench

CAESAR_DIGIT_STEPPER -- requirements
Module: caesar_digit_stepper

---
 rtl/caesar_digit_stepper_pkg.sv | 22 ++
 rtl/caesar_digit_stepper_if.sv | 15 +
 rtl/caesar_shift.sv | 27 ++
 rtl/caesar_digit_stepper.sv | 111 +++++++++++
 tb/tb_caesar_digit_stepper.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/caesar_digit_stepper_pkg.sv
// Shared types and constants for the Caesar digit stepper.
package caesar_digit_stepper_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MOD = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Non-BCD input codes (10-15) are treated as the digit 0.
  function automatic logic [BCD_W-1:0] clean_digit(input logic [BCD_W-1:0] v);
    return (v >= BCD_W'(BCD_MOD)) ? '0 : v;
  endfunction

  // Shift amounts 10-15 wrap back into 0-5 so the shifter only sees 0-9.
  function automatic logic [BCD_W-1:0] fold_key(input logic [BCD_W-1:0] v);
    return (v >= BCD_W'(BCD_MOD)) ? BCD_W'(v - BCD_W'(BCD_MOD)) : v;
  endfunction

endpackage

// File: rtl/caesar_digit_stepper_if.sv
// Load-side digit handshake.
// Handshake: a digit transfers on a rising clock edge where in_valid=1 and
// in_ready=1; in_digit must be stable while in_valid is high, and in_ready
// may drop at any time without regard to in_valid.
interface caesar_digit_stepper_if;
  import caesar_digit_stepper_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BCD_W-1:0] in_digit;

  modport master (output in_valid, output in_digit, input in_ready);
  modport slave  (input in_valid, input in_digit, output in_ready);

endinterface

// File: rtl/caesar_shift.sv
// Combinational Caesar shift of one BCD digit, modulo 10.
module caesar_shift
  import caesar_digit_stepper_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic [BCD_W-1:0] key,
  input  logic             decrypt,
  output logic [BCD_W-1:0] shifted
);

  logic [BCD_W:0] sum;

  // Sum is one bit wider than a digit so d+k (<=18) and d+10-k (<=19) never wrap.
  always_comb begin
    if (decrypt) begin
      sum = {1'b0, digit} + (BCD_W+1)'(BCD_MOD) - {1'b0, key};
    end else begin
      sum = {1'b0, digit} + {1'b0, key};
    end
    if (sum >= (BCD_W+1)'(BCD_MOD)) begin
      shifted = BCD_W'(sum - (BCD_W+1)'(BCD_MOD));
    end else begin
      shifted = sum[BCD_W-1:0];
    end
  end

endmodule

// File: rtl/caesar_digit_stepper.sv
// Loads a short BCD message, then steps its Caesar-shifted digits out one per tick.
module caesar_digit_stepper
  import caesar_digit_stepper_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  caesar_digit_stepper_if.slave   in_if,
  input  logic [BCD_W-1:0]        key,
  input  logic                    decrypt,
  input  logic                    start,
  input  logic                    tick,
  output logic [BCD_W-1:0]        bcd,
  output logic                    busy,
  output logic                    done,
  output state_t                  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    count;
  logic [CW-1:0]    rd_ptr;
  logic [BCD_W-1:0] buf_mem [DEPTH];
  logic [BCD_W-1:0] key_q;
  logic             dec_q;
  logic [BCD_W-1:0] shifted;

  logic xfer;
  logic go;
  logic step;
  logic finish;

  // Handshake and control strobes derived from the current state.
  always_comb begin
    in_if.in_ready = (state == IDLE) && (count < CW'(DEPTH));
    xfer           = in_if.in_valid && in_if.in_ready;
    // A digit arriving on the start cycle counts toward a non-empty message.
    go             = (state == IDLE) && start && ((count != '0) || xfer);
    step           = (state == RUN) && tick && (rd_ptr < count);
    finish         = (state == RUN) && tick && (rd_ptr == count);
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_nx  = state;
    busy      = (state == RUN);
    dbg_state = state;
    case (state)
      IDLE:    if (go)     state_nx = RUN;
      RUN:     if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Message buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge CLOCK_50) begin
    if (xfer) begin
      buf_mem[count[AW-1:0]] <= clean_digit(in_if.in_digit);
    end
  end

  caesar_shift u_shift (
    .digit   (buf_mem[rd_ptr[AW-1:0]]),
    .key     (key_q),
    .decrypt (dec_q),
    .shifted (shifted)
  );

  // Counters, latched run settings, displayed digit and completion pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      bcd    <= '0;
      done   <= 1'b0;
      key_q  <= '0;
      dec_q  <= 1'b0;
    end else begin
      done <= finish;
      if (xfer) begin
        count <= count + CW'(1);
      end
      if (go) begin
        key_q  <= fold_key(key);
        dec_q  <= decrypt;
        rd_ptr <= '0;
      end
      if (step) begin
        bcd    <= shifted;
        rd_ptr <= rd_ptr + CW'(1);
      end
      if (finish) begin
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_caesar_digit_stepper.sv
// Directed and randomized checks of the Caesar digit stepper against a digit-queue model.
module tb_caesar_digit_stepper;
  import caesar_digit_stepper_pkg::*;

  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic       reset;
  logic [3:0] key;
  logic       decrypt;
  logic       start;
  logic       tick;
  logic [3:0] bcd;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  caesar_digit_stepper_if bus ();

  caesar_digit_stepper #(.DEPTH(DEPTH)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .in_if     (bus),
    .key       (key),
    .decrypt   (decrypt),
    .start     (start),
    .tick      (tick),
    .bcd       (bcd),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];   // plaintext digits the DUT should hold, in load order
  int exp_bcd = 0;        // digit the display should currently show

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_shift(input int d, input int k, input bit dec);
    int kk;
    kk = k % 10;
    return dec ? (d + 10 - kk) % 10 : (d + kk) % 10;
  endfunction

  function automatic logic [3:0] ref_clean(input int d);
    return (d > 9) ? 4'd0 : 4'(d);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input int d);
    bus.in_valid = 1'b1;
    bus.in_digit = 4'(d);
    cyc();
    bus.in_valid = 1'b0;
    exp_q.push_back(ref_clean(d));
  endtask

  task automatic start_run(input string tag, input int k, input bit dec);
    key     = 4'(k);
    decrypt = dec;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    check({tag, "_busy_on_start"}, 8'(busy), 8'd1);
    check({tag, "_bcd_hold_on_start"}, 8'(bcd), 8'(exp_bcd));
  endtask

  // Steps through every queued digit, then the closing tick; key/decrypt
  // inputs are scrambled after start to show they were latched.
  task automatic step_run(input string tag, input int k, input bit dec, input int gap_max);
    int n;
    n = exp_q.size();
    key     = 4'($urandom_range(0, 15));
    decrypt = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        cyc();
        check({tag, "_bcd_hold_gap"}, 8'(bcd), 8'(exp_bcd));
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      exp_bcd = ref_shift(int'(exp_q[i]), k, dec);
      check({tag, "_bcd_step"}, 8'(bcd), 8'(exp_bcd));
      check({tag, "_no_done_mid"}, 8'(done), 8'd0);
      check({tag, "_ready_low_run"}, 8'(bus.in_ready), 8'd0);
    end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check({tag, "_done_pulse"}, 8'(done), 8'd1);
    check({tag, "_busy_off"}, 8'(busy), 8'd0);
    check({tag, "_bcd_hold_last"}, 8'(bcd), 8'(exp_bcd));
    check({tag, "_ready_after"}, 8'(bus.in_ready), 8'd1);
    cyc();
    check({tag, "_done_one_cycle"}, 8'(done), 8'd0);
    exp_q.delete();
  endtask

  task automatic full_run(input string tag, input int k, input bit dec, input int gap_max);
    start_run(tag, k, dec);
    step_run(tag, k, dec, gap_max);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int d;
    int k;
    bit dec;
    int n;

    reset        = 1'b1;
    key          = '0;
    decrypt      = 1'b0;
    start        = 1'b0;
    tick         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_digit = '0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    check("rst_bcd", 8'(bcd), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_ready", 8'(bus.in_ready), 8'd1);
    check("rst_state", 8'(dbg_state), 8'(IDLE));

    // Encrypt 3,7,9 with key 4 -> 7,1,3
    push(3); push(7); push(9);
    full_run("enc349", 4, 1'b0, 2);
    check("enc349_last_is_3", 8'(bcd), 8'd3);

    // Decrypt 7,1,3 with key 4 -> 3,7,9
    push(7); push(1); push(3);
    full_run("dec413", 4, 1'b1, 2);
    check("dec413_last_is_9", 8'(bcd), 8'd9);

    // Tick in IDLE leaves the display alone
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("idle_tick_bcd", 8'(bcd), 8'(exp_bcd));
    check("idle_tick_busy", 8'(busy), 8'd0);

    // Hold in_valid for 10 cycles: exactly DEPTH digits accepted
    acc = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = $urandom_range(0, 15);
      bus.in_digit = 4'(d);
      if (bus.in_ready) acc++;
      if (i < DEPTH) exp_q.push_back(ref_clean(d));
      cyc();
    end
    bus.in_valid = 1'b0;
    check("full_accept_count", 8'(acc), 8'(DEPTH));
    check("full_ready_low", 8'(bus.in_ready), 8'd0);
    full_run("full", 6, 1'b0, 1);

    // Key 13 folds to 3; digit 12 stored as 0 -> display 3
    push(12);
    full_run("key13", 13, 1'b0, 0);
    check("key13_bcd_is_3", 8'(bcd), 8'd3);

    // Start with an empty buffer is ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("empty_start_busy", 8'(busy), 8'd0);
    cyc();
    check("empty_start_busy_later", 8'(busy), 8'd0);
    check("empty_start_state", 8'(dbg_state), 8'(IDLE));

    // Reset after the 2nd tick of a 5-digit run
    for (int i = 0; i < 5; i++) push($urandom_range(0, 9));
    k = $urandom_range(0, 15);
    dec = 1'($urandom_range(0, 1));
    start_run("midrst", k, dec);
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      exp_bcd = ref_shift(int'(exp_q[i]), k, dec);
      check("midrst_bcd_step", 8'(bcd), 8'(exp_bcd));
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    exp_bcd = 0;
    check("midrst_bcd", 8'(bcd), 8'd0);
    check("midrst_busy", 8'(busy), 8'd0);
    check("midrst_ready", 8'(bus.in_ready), 8'd1);
    check("midrst_done", 8'(done), 8'd0);
    cyc();
    check("midrst_done_later", 8'(done), 8'd0);

    // start, tick and a transfer on the same cycle
    push(5);
    k = $urandom_range(0, 15);
    dec = 1'($urandom_range(0, 1));
    d = $urandom_range(0, 15);
    key          = 4'(k);
    decrypt      = dec;
    start        = 1'b1;
    tick         = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_digit = 4'(d);
    exp_q.push_back(ref_clean(d));
    cyc();
    start        = 1'b0;
    tick         = 1'b0;
    bus.in_valid = 1'b0;
    check("same_cyc_busy", 8'(busy), 8'd1);
    check("same_cyc_bcd_hold", 8'(bcd), 8'(exp_bcd));
    check("same_cyc_ready_low", 8'(bus.in_ready), 8'd0);
    step_run("same_cyc", k, dec, 1);

    // Randomized messages
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push($urandom_range(0, 15));
      full_run("rand", $urandom_range(0, 15), 1'($urandom_range(0, 1)), 3);
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
